// File: rtl/color_seq_pkg.sv
// Shared definitions for the colour sequencer: mode encodings, sequence
// length and the colour table feeding the breathing-light stage.
package color_seq_pkg;

  typedef enum logic [1:0] {
    MODE_AUTO   = 2'd0,
    MODE_HOLD   = 2'd1,
    MODE_MANUAL = 2'd2
  } mode_e;

  localparam int unsigned SEQ_LEN = 7;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned RGB_W   = 3;

  // Entry i lives at bits [3*i +: 3]; entry 0 is the least significant.
  localparam logic [RGB_W*SEQ_LEN-1:0] COLOR_TABLE = {
    3'b111, 3'b101, 3'b110, 3'b011, 3'b100, 3'b010, 3'b001
  };

  // Table lookup; out-of-range indices fall back to entry 0.
  function automatic logic [RGB_W-1:0] color_lut(input logic [IDX_W-1:0] idx);
    int unsigned i;
    i = 32'(idx);
    if (i >= SEQ_LEN) i = 0;
    return COLOR_TABLE[RGB_W*i +: RGB_W];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a registered
// one-cycle press pulse on each accepted 0->1 transition.
//   clk_div_i : system clock
//   rst_i     : synchronous active-high reset
//   btn_i     : raw asynchronous button level
//   press_o   : one-cycle press pulse (registered)
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic clk_div_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic             level_prev_q;
  logic [CNT_W-1:0] cnt_q;

  // Counter only runs while the synchronised level disagrees with the
  // accepted level, so any glitch shorter than the window restarts it.
  always_ff @(posedge clk_div_i) begin
    if (rst_i) begin
      sync_q1      <= 1'b0;
      sync_q2      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
      press_o      <= 1'b0;
    end else begin
      sync_q1 <= btn_i;
      sync_q2 <= sync_q1;
      if (sync_q2 == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level_q <= sync_q2;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      level_prev_q <= level_q;
      press_o      <= level_q & ~level_prev_q;
    end
  end

endmodule

// File: rtl/color_sequencer.sv
// Colour-selection stage ahead of the breathing-light PWM. Steps through the
// colour table on breath-cycle rising edges (AUTO), freezes (HOLD), or steps
// on the step button (MANUAL); the mode button cycles the mode.
//   clk_div_i    : system clock (shared with the breather)
//   rst_i        : synchronous active-high reset
//   breath_tgl_i : breath-cycle toggle, already registered in this domain
//   btn_mode_i   : raw mode button
//   btn_step_i   : raw step button
//   rgb_o        : current colour (registered)
//   mode_o       : current mode, 0 AUTO / 1 HOLD / 2 MANUAL (registered)
//   step_pulse_o : one-cycle pulse coinciding with an rgb_o change
module color_sequencer
  import color_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic       clk_div_i,
  input  logic       rst_i,
  input  logic       breath_tgl_i,
  input  logic       btn_mode_i,
  input  logic       btn_step_i,
  output logic [2:0] rgb_o,
  output logic [1:0] mode_o,
  output logic       step_pulse_o
);

  logic             mode_press;
  logic             step_press;
  logic             breath_q;
  logic             breath_edge_c;
  logic             advance_c;
  mode_e            mode_q;
  mode_e            mode_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk_div_i (clk_div_i),
    .rst_i     (rst_i),
    .btn_i     (btn_mode_i),
    .press_o   (mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk_div_i (clk_div_i),
    .rst_i     (rst_i),
    .btn_i     (btn_step_i),
    .press_o   (step_press)
  );

  // Rising edge of the breath toggle marks the darkest point of the cycle.
  assign breath_edge_c = breath_tgl_i & ~breath_q;

  // Advance decision uses the mode held before this cycle's mode press.
  always_comb begin
    mode_d    = mode_q;
    idx_d     = idx_q;
    advance_c = 1'b0;

    case (mode_q)
      MODE_AUTO:   advance_c = breath_edge_c;
      MODE_MANUAL: advance_c = step_press;
      default:     advance_c = 1'b0;
    endcase

    if (mode_press) begin
      case (mode_q)
        MODE_AUTO: mode_d = MODE_HOLD;
        MODE_HOLD: mode_d = MODE_MANUAL;
        default:   mode_d = MODE_AUTO;
      endcase
    end

    if (advance_c) begin
      idx_d = (idx_q == IDX_W'(SEQ_LEN - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk_div_i) begin
    if (rst_i) begin
      breath_q     <= 1'b0;
      mode_q       <= MODE_AUTO;
      idx_q        <= '0;
      rgb_o        <= color_lut('0);
      step_pulse_o <= 1'b0;
    end else begin
      breath_q     <= breath_tgl_i;
      mode_q       <= mode_d;
      idx_q        <= idx_d;
      rgb_o        <= color_lut(idx_d);
      step_pulse_o <= advance_c;
    end
  end

  assign mode_o = mode_q;

endmodule

// File: doc/color_sequencer.md
# color_sequencer

Colour-selection stage directly upstream of the breathing-light PWM stage. It supplies the 3-bit `rgb` colour that the breather masks, and consumes the breather's breath-cycle toggle output to change colour while the LED is at its darkest point. Two push-buttons select the sequencing mode and manually step the colour. The block runs on the same clock domain as the breather.

## Interface
- `DEBOUNCE_CYCLES`, default 65536: consecutive stable cycles required before a button level is accepted. Legal range is 2..2^20.
- `clk_div_i`  in  1  System clock; same clock as the breather.
- `rst_i`  in  1  Reset. Synchronous, active-high.
- `breath_tgl_i`  in  1  Breath-cycle toggle from the breather. It is registered in `clk_div_i`, so no synchroniser is used.
- `btn_mode_i`  in  1  Raw mode button, asynchronous, active-high.
- `btn_step_i`  in  1  Raw step button, asynchronous, active-high.
- `rgb_o`  out  3  Current colour, registered. Feeds the breather's `rgb_i`.
- `mode_o`  out  2  Current mode: 0 = AUTO, 1 = HOLD, 2 = MANUAL.
- `step_pulse_o`  out  1  One-cycle pulse, high in the same cycle `rgb_o` changes.

## Operation
- **Colour table (index 0..6):**
  - 0: 3'b001
  - 1: 3'b010
  - 2: 3'b100
  - 3: 3'b011
  - 4: 3'b110
  - 5: 3'b101
  - 6: 3'b111
  - An advance from index 6 wraps to index 0.
- **Breath edge:** `breath_q` holds the previous-cycle value of `breath_tgl_i`. A breath edge is `breath_tgl_i & ~breath_q`, rising edges only. The rising edge marks the darkest point of the cycle.
- **Buttons:**
  - Each button passes through a 2-FF synchroniser, then a debouncer.
  - The debouncer counter clears whenever the synchronised level differs from the accepted level.
  - When the count reaches `DEBOUNCE_CYCLES-1`, the accepted level takes the synchronised level and the counter clears.
  - A press is a one-cycle pulse on a 0→1 transition of the accepted level. Releases generate nothing.
- **Mode FSM:** AUTO → HOLD → MANUAL → AUTO, advancing on each mode press.
- **Advance conditions:**
  - AUTO: advance on a breath edge. Step presses are ignored.
  - HOLD: never advance.
  - MANUAL: advance on a step press. Breath edges are ignored.
- **Simultaneous events:**
  - The advance decision uses the mode value held before that cycle's mode press.
  - A mode press and a qualifying advance in the same cycle both take effect.
- **Reset values:**
  - index = 0, `rgb_o` = 3'b001
  - `mode_o` = 0 (AUTO)
  - `step_pulse_o` = 0
  - `breath_q` = 0, synchroniser flops = 0, accepted levels = 0, debounce counters = 0
- **Reset while a button is held:** after release of reset, the held button produces exactly one press once debounce completes.

## Timing
- **Breath edge latency:** `breath_tgl_i` rises, sampled at edge N. `rgb_o` and `step_pulse_o` update at edge N+1, which is 1 cycle of latency.
- **Button latency:** a raw level is stable from edge M. The press pulse is high after edge M+2+DEBOUNCE_CYCLES. `rgb_o` or `mode_o` update one edge later.
- **Bounce:** any raw glitch shorter than `DEBOUNCE_CYCLES` cycles produces no press.
- **Pulse widths:** `step_pulse_o` is exactly one cycle wide. Back-to-back breath edges cannot occur, since the breath period is far greater than 2 cycles.
- **Output timing:** all outputs are driven directly from flops. There are no combinational input-to-output paths.

## Structure
- **Package `color_seq_pkg`:**
  - Mode encodings `MODE_AUTO`, `MODE_HOLD`, `MODE_MANUAL`.
  - `SEQ_LEN` = 7.
  - The 7-entry colour constant table.
- **Sub-module `btn_debounce`** (parameter `DEBOUNCE_CYCLES`):
  - Contains the 2-FF synchroniser, the counter of width $clog2(DEBOUNCE_CYCLES), the accepted-level flop, and the press-pulse output.
  - Instantiated twice.
- **Top level:** breath edge detector, mode FSM, 3-bit index register, and a table lookup registered into `rgb_o`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- **Reset:** assert `rst_i` for 3 cycles with random inputs → `rgb_o` = 001, `mode_o` = 0 and `step_pulse_o` = 0 at every edge while reset is asserted and on the first edge after it.
- **AUTO wrap:** drive 8 rising breath edges, each 10 cycles apart → `rgb_o` steps 010, 100, 011, 110, 101, 111, 001, 010. Each change lands 1 cycle after the edge and coincides with `step_pulse_o`. Falling edges cause no change.
- **Debounce:**
  - Mode button bounces 1-0-1-0 with 1-cycle pulses, then holds high for 10 cycles → exactly one mode press, `mode_o` 0 → 1.
  - The press pulse appears at edge M+6, where M is the edge at which the raw level becomes stable; `mode_o` = 1 at edge M+7.
- **HOLD:** in HOLD, drive breath edges and step presses → `rgb_o` is unchanged and `step_pulse_o` stays 0.
- **MANUAL:**
  - Three step presses → index advances 0 → 3, so `rgb_o` = 011.
  - Breath edges are ignored.
  - A further mode press → `mode_o` = 0.
- **Simultaneous events:** in AUTO, align a breath edge with a debounced mode press in the same cycle → colour advances once and `mode_o` becomes 1 in the same cycle. Assert `rst_i` mid-sequence → state returns to the reset values on the next edge.
